// File: rtl/sdiv_pkg.sv
// Shared types and widths for the sdiv request sequencer and its watchdog.
package sdiv_pkg;
  localparam int DBUS_W     = 16;
  localparam int DIVIDEND_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HI,
    S_SEND_LO,
    S_SEND_DV,
    S_WAIT,
    S_OUT
  } sdiv_seq_state_t;
endpackage

// File: rtl/sdiv_wdog.sv
// Completion watchdog: counts enabled cycles after a clear, flags the cycle
// in which the count reaches TIMEOUT_CYCLES.
module sdiv_wdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TO_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // tc fires in the cycle whose increment would make the count TIMEOUT_CYCLES
  assign tc = en && (cnt == TO_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/sdiv_seq.sv
// Request sequencer for the 16-bit signed divider: serialises operands onto
// Dbus, waits for Rdy with a watchdog, and returns results on valid/ready.
module sdiv_seq
  import sdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] in_dividend,
  input  logic signed [DBUS_W-1:0]     in_divisor,
  output logic                         div_st,
  output logic        [DBUS_W-1:0]     div_dbus,
  input  logic                         div_rdy,
  input  logic signed [DBUS_W-1:0]     div_quot,
  input  logic signed [DBUS_W-1:0]     div_rem,
  input  logic                         div_v,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DBUS_W-1:0]     out_quot,
  output logic signed [DBUS_W-1:0]     out_rem,
  output logic                         out_ovf,
  output logic                         out_dz,
  output logic                         out_to
);
  sdiv_seq_state_t state, state_nx;

  logic                         armed;
  logic                         hs;
  logic signed [DIVIDEND_W-1:0] op_dividend;
  logic signed [DBUS_W-1:0]     op_divisor;
  logic        [DBUS_W-1:0]     dbus_nx;
  logic                         load_res;
  logic signed [DBUS_W-1:0]     quot_nx, rem_nx;
  logic                         ovf_nx, dz_nx, to_nx;
  logic                         wd_clr, wd_en, wd_tc;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready = armed && (state == S_IDLE) && div_rdy;
  assign hs       = in_valid && in_ready;

  sdiv_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_wdog (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  always_comb begin
    state_nx = state;
    dbus_nx  = '0;
    load_res = 1'b0;
    quot_nx  = '0;
    rem_nx   = '0;
    ovf_nx   = 1'b0;
    dz_nx    = 1'b0;
    to_nx    = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hs) begin
          if (in_divisor == '0) begin
            state_nx = S_OUT;
            load_res = 1'b1;
            ovf_nx   = 1'b1;
            dz_nx    = 1'b1;
          end else begin
            state_nx = S_SEND_HI;
            dbus_nx  = in_dividend[DIVIDEND_W-1 -: DBUS_W];
          end
        end
      end
      S_SEND_HI: begin
        state_nx = S_SEND_LO;
        dbus_nx  = op_dividend[DBUS_W-1:0];
      end
      S_SEND_LO: begin
        state_nx = S_SEND_DV;
        dbus_nx  = op_divisor;
      end
      S_SEND_DV: begin
        state_nx = S_WAIT;
        wd_clr   = 1'b1;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        // a completion in the terminal cycle takes priority over the timeout
        if (div_rdy) begin
          state_nx = S_OUT;
          load_res = 1'b1;
          quot_nx  = div_quot;
          rem_nx   = div_rem;
          ovf_nx   = div_v;
        end else if (wd_tc) begin
          state_nx = S_OUT;
          load_res = 1'b1;
          ovf_nx   = 1'b1;
          to_nx    = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // control and output registers: Dbus/St are registered from the next state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      div_st    <= 1'b0;
      div_dbus  <= '0;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_ovf   <= 1'b0;
      out_dz    <= 1'b0;
      out_to    <= 1'b0;
    end else begin
      state     <= state_nx;
      armed     <= 1'b1;
      div_st    <= (state_nx == S_SEND_HI);
      div_dbus  <= dbus_nx;
      out_valid <= (state_nx == S_OUT);
      if (load_res) begin
        out_quot <= quot_nx;
        out_rem  <= rem_nx;
        out_ovf  <= ovf_nx;
        out_dz   <= dz_nx;
        out_to   <= to_nx;
      end
    end
  end

  // operand capture on handshake
  always_ff @(posedge CLK) begin
    if (hs) begin
      op_dividend <= in_dividend;
      op_divisor  <= in_divisor;
    end
  end
endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq with a behavioural divider that mimics the sdiv
// St/Dbus/Rdy protocol, including early overflow exit and a hang mode.
module tb_sdiv_seq;
  localparam int TIMEOUT = 64;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_dividend = '0;
  logic signed [15:0] in_divisor = '0;
  logic               div_st;
  logic [15:0]        div_dbus;
  logic               div_rdy = 1'b1;
  logic [15:0]        div_quot = '0;
  logic [15:0]        div_rem = '0;
  logic               div_v = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_quot;
  logic signed [15:0] out_rem;
  logic               out_ovf, out_dz, out_to;

  int n_checks = 0;
  int n_fail = 0;
  int st_seen = 0;

  always #5 CLK = ~CLK;

  sdiv_seq #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(7)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_st(div_st), .div_dbus(div_dbus), .div_rdy(div_rdy),
    .div_quot(div_quot), .div_rem(div_rem), .div_v(div_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem),
    .out_ovf(out_ovf), .out_dz(out_dz), .out_to(out_to)
  );

  // ---------------- behavioural divider (no reset, like the real one) -----
  function automatic logic [32:0] ref_div(input longint a, input longint b);
    longint q, r;
    if (b == 0) return '0;
    q = a / b;
    r = a % b;
    return {(q > 32767 || q < -32768), q[15:0], r[15:0]};
  endfunction

  int          mdl_phase = 0;
  int          mdl_cnt = 0;
  logic [15:0] mdl_hi = '0, mdl_lo = '0;
  logic [32:0] mdl_res = '0;
  logic [32:0] mdl_next;
  bit          mdl_hang = 1'b0;

  assign mdl_next = ref_div(longint'($signed({mdl_hi, mdl_lo})), longint'($signed(div_dbus)));

  always @(posedge CLK) begin
    case (mdl_phase)
      0: if (div_st) begin
        mdl_hi    <= div_dbus;
        div_rdy   <= 1'b0;
        mdl_phase <= 1;
      end
      1: begin
        mdl_lo    <= div_dbus;
        mdl_phase <= 2;
      end
      2: begin
        mdl_res   <= mdl_next;
        mdl_cnt   <= mdl_next[32] ? 2 : 32;
        mdl_phase <= 3;
      end
      default: if (!mdl_hang) begin
        if (mdl_cnt <= 1) begin
          div_rdy                      <= 1'b1;
          {div_v, div_quot, div_rem}   <= mdl_res;
          mdl_phase                    <= 0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    endcase
  end

  always @(posedge CLK) if (div_st) st_seen <= st_seen + 1;

  // ---------------- stimulus helpers (no checking inside) -----------------
  task automatic drive_req(input logic signed [31:0] a, input logic signed [15:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (in_ready) begin
      in_dividend = a;
      in_divisor  = b;
      in_valid    = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      ok       = 1'b1;
    end
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic consume(input int d);
    repeat (d) @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  // ---------------- tests -----------------
  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({in_ready, out_valid, div_st, out_ovf, out_dz, out_to} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000", {in_ready, out_valid, div_st, out_ovf, out_dz, out_to});
    end
    n_checks++;
    if ({div_dbus, out_quot, out_rem} !== 48'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {div_dbus, out_quot, out_rem});
    end
    RST_N = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 0", in_ready);
    end
    @(negedge CLK);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_first_clock: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    bit ok; int n; int st0;
    st0 = st_seen;
    drive_req(32'sd100, 16'sd7, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_handshake: got none required handshake"); end
    n_checks++;
    if ({div_st, div_dbus} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL basic_send_hi: got st=%b bus=%h required st=1 bus=0000", div_st, div_dbus);
    end
    @(negedge CLK);
    n_checks++;
    if ({div_st, div_dbus} !== {1'b0, 16'h0064}) begin
      n_fail++; $display("FAIL basic_send_lo: got st=%b bus=%h required st=0 bus=0064", div_st, div_dbus);
    end
    @(negedge CLK);
    n_checks++;
    if ({div_st, div_dbus} !== {1'b0, 16'h0007}) begin
      n_fail++; $display("FAIL basic_send_dv: got st=%b bus=%h required st=0 bus=0007", div_st, div_dbus);
    end
    @(negedge CLK);
    n_checks++;
    if ({div_st, div_dbus} !== 17'h0) begin
      n_fail++; $display("FAIL basic_bus_idle: got st=%b bus=%h required 0", div_st, div_dbus);
    end
    wait_valid(n, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_valid: got no out_valid required out_valid"); end
    n_checks++;
    if ({out_quot, out_rem, out_ovf, out_dz, out_to} !== {16'd14, 16'd2, 3'b000}) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d ovf=%b dz=%b to=%b required q=14 r=2 flags 0",
               out_quot, out_rem, out_ovf, out_dz, out_to);
    end
    n_checks++;
    if (st_seen - st0 !== 1) begin
      n_fail++; $display("FAIL basic_st_count: got %0d required 1", st_seen - st0);
    end
    consume(0);
  endtask

  task automatic test_negative;
    bit ok; int n;
    drive_req(-32'sd100, 16'sd7, ok);
    wait_valid(n, ok);
    n_checks++;
    if ({out_valid, out_quot, out_rem, out_ovf} !== {1'b1, 16'hFFF2, 16'hFFFE, 1'b0}) begin
      n_fail++;
      $display("FAIL negative_result: got v=%b q=%h r=%h ovf=%b required v=1 q=fff2 r=fffe ovf=0",
               out_valid, out_quot, out_rem, out_ovf);
    end
    consume(1);
  endtask

  task automatic test_early_exit;
    bit ok; int n;
    drive_req(32'sh0001_0000, 16'sd1, ok);
    wait_valid(n, ok);
    n_checks++;
    if ({out_valid, out_ovf, out_dz, out_to} !== 4'b1100) begin
      n_fail++;
      $display("FAIL early_exit_flags: got v=%b ovf=%b dz=%b to=%b required 1100", out_valid, out_ovf, out_dz, out_to);
    end
    n_checks++;
    if (n > 10) begin
      n_fail++; $display("FAIL early_exit_latency: got %0d cycles required <= 10", n);
    end
    consume(0);
  endtask

  task automatic test_div_zero;
    bit ok; int st0;
    st0 = st_seen;
    drive_req($signed($urandom), 16'sd0, ok);
    n_checks++;
    if ({out_valid, out_ovf, out_dz, out_to, out_quot, out_rem} !== {4'b1110, 32'h0}) begin
      n_fail++;
      $display("FAIL div_zero_result: got v=%b ovf=%b dz=%b to=%b q=%h r=%h required v=1 ovf=1 dz=1 to=0 q=r=0",
               out_valid, out_ovf, out_dz, out_to, out_quot, out_rem);
    end
    consume(2);
    n_checks++;
    if (st_seen !== st0) begin
      n_fail++; $display("FAIL div_zero_no_st: got %0d strobes required 0", st_seen - st0);
    end
  endtask

  task automatic test_random;
    bit ok; int n;
    logic signed [31:0] a;
    logic signed [15:0] b;
    longint eq, er;
    bit ev;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) a = $signed($urandom_range(200000, 0)) - 32'sd100000;
      else            a = $signed($urandom);
      b  = $signed(16'($urandom_range(65535, 1)));
      eq = longint'(a) / longint'(b);
      er = longint'(a) % longint'(b);
      ev = (eq > 32767) || (eq < -32768);
      drive_req(a, b, ok);
      wait_valid(n, ok);
      n_checks++;
      if (!ok || out_ovf !== ev || out_dz !== 1'b0 || out_to !== 1'b0 ||
          (!ev && (out_quot !== 16'(eq) || out_rem !== 16'(er)))) begin
        n_fail++;
        $display("FAIL random_%0d %0d/%0d: got v=%b q=%0d r=%0d ovf=%b dz=%b to=%b required q=%0d r=%0d ovf=%b",
                 i, a, b, out_valid, out_quot, out_rem, out_ovf, out_dz, out_to, eq, er, ev);
      end
      consume($urandom_range(3, 0));
    end
  endtask

  task automatic test_backpressure;
    bit ok; int n; bit bad;
    drive_req(32'sd100, 16'sd7, ok);
    wait_valid(n, ok);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      bad = !(out_valid === 1'b1 && out_quot === 16'sd14 && out_rem === 16'sd2 && in_ready === 1'b0);
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got v=%b q=%0d r=%0d in_ready=%b required v=1 q=14 r=2 in_ready=0",
                 c, out_valid, out_quot, out_rem, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_timeout;
    bit ok; int n;
    mdl_hang = 1'b1;
    drive_req(32'sd1000, 16'sd3, ok);
    // counting starts in the SEND_HI cycle; WAIT begins three cycles later
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (n !== TIMEOUT + 3) begin
      n_fail++; $display("FAIL timeout_latency: got %0d required %0d", n, TIMEOUT + 3);
    end
    n_checks++;
    if ({out_valid, out_to, out_ovf, out_dz, out_quot, out_rem} !== {4'b1110, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_result: got v=%b to=%b ovf=%b dz=%b q=%h r=%h required v=1 to=1 ovf=1 dz=0 q=r=0",
               out_valid, out_to, out_ovf, out_dz, out_quot, out_rem);
    end
    consume(0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL timeout_busy_ready: got %b required 0", in_ready);
    end
    mdl_hang = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok; int n; bit viol;
    drive_req(32'sd100, 16'sd7, ok);
    repeat (6) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, div_st, div_dbus, out_quot, out_rem, out_ovf, out_dz, out_to} !== 54'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ready=%b v=%b st=%b bus=%h q=%h r=%h flags=%b%b%b required all 0",
               in_ready, out_valid, div_st, div_dbus, out_quot, out_rem, out_ovf, out_dz, out_to);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    viol = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (in_ready && !div_rdy) viol = 1'b1;
    end while (!in_ready && n < 200);
    n_checks++;
    if (viol || in_ready !== 1'b1 || n <= 5) begin
      n_fail++;
      $display("FAIL midreset_ready_gate: got viol=%b ready=%b after %0d cycles required ready only once divider idle",
               viol, in_ready, n);
    end
    drive_req(32'sd100, 16'sd7, ok);
    wait_valid(n, ok);
    n_checks++;
    if ({out_valid, out_quot, out_rem, out_ovf} !== {1'b1, 16'd14, 16'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_next_req: got v=%b q=%0d r=%0d ovf=%b required v=1 q=14 r=2 ovf=0",
               out_valid, out_quot, out_rem, out_ovf);
    end
    consume(0);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_negative();
    test_early_exit();
    test_div_zero();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion required completion within 50000 cycles");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/sdiv_seq.md
Name: sdiv_seq

Overview:
- Upstream request sequencer for the 16-bit signed divider (sdiv).
- Accepts one 32-bit signed dividend and one 16-bit signed divisor per transaction on a valid/ready input port.
- Serialises the operands onto the divider's shared 16-bit Dbus using the St strobe: high dividend word, then low dividend word, then divisor.
- Waits for the divider's Rdy, captures Quotient/Remainder/V, and returns them on a valid/ready output port.
- Adds divide-by-zero short-circuit and a completion watchdog, because the divider itself has neither reset nor error reporting.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before aborting with a timeout error.
- TO_W, 7: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  single system clock; all logic on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  request operands valid.
- in_ready  output  1  sequencer can accept a request.
- in_dividend  input  32  signed dividend.
- in_divisor  input  16  signed divisor.
- div_st  output  1  start strobe to divider St.
- div_dbus  output  16  operand bus to divider Dbus.
- div_rdy  input  1  divider Rdy (high = idle).
- div_quot  input  16  divider Quotient.
- div_rem  input  16  divider Remainder.
- div_v  input  1  divider overflow V.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_quot  output  16  signed quotient.
- out_rem  output  16  signed remainder.
- out_ovf  output  1  overflow, or divide-by-zero.
- out_dz  output  1  divide-by-zero flag.
- out_to  output  1  watchdog timeout flag.

Behaviour:
- Reset values (async, RST_N low): state IDLE; in_ready=0 until the first clock after release; div_st=0; div_dbus=0; out_valid=0; out_quot, out_rem, out_ovf, out_dz, out_to all 0; watchdog=0.
- States: IDLE, SEND_HI, SEND_LO, SEND_DV, WAIT, OUT.
- in_ready=1 only in IDLE with div_rdy=1. A handshake (in_valid & in_ready) latches both operands into op registers.
- IDLE:
  - Handshake with in_divisor==0: go directly to OUT with quot=0, rem=0, out_ovf=1, out_dz=1. The divider is not launched.
  - Handshake otherwise: go to SEND_HI.
- SEND_HI: div_st=1, div_dbus=dividend[31:16]; next SEND_LO.
- SEND_LO: div_st=0, div_dbus=dividend[15:0]; next SEND_DV.
- SEND_DV: div_dbus=divisor; next WAIT. Clear the watchdog.
- div_st is high for exactly one cycle per transaction. div_dbus is registered and driven 0 outside the SEND states.
- WAIT:
  - Watchdog increments each cycle.
  - div_rdy=1: capture div_quot, div_rem, div_v into out regs; go to OUT.
  - Watchdog reaches TIMEOUT_CYCLES: go to OUT with out_to=1, out_ovf=1, quot=rem=0.
  - div_rdy=1 in the same cycle the watchdog reaches TIMEOUT_CYCLES: the capture wins and out_to=0.
  - The divider's early-overflow exit (Rdy returns about 2 cycles after SEND_DV) is a normal completion with out_ovf=1.
- OUT: out_valid=1. Outputs hold stable until out_ready=1, then return to IDLE with out_valid=0 on the next cycle. out_ready is ignored when out_valid=0.
- Latency:
  - Three cycles from handshake to divider loaded, plus divider run time, plus one capture cycle.
  - Normal divide: about 36 cycles total. Divide-by-zero: 1 cycle to out_valid.
- Throughput: one transaction in flight. No new handshake before the OUT handshake completes.
- Reset mid-operation: the divider has no reset and may still be busy. After RST_N rises, IDLE keeps in_ready low until div_rdy=1, so the divider is never restarted while busy.
- Arithmetic: no sign handling here; the divider handles signs.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- div_st is never asserted while div_rdy=0.

Decomposition:
- Shared package sdiv_pkg:
  - state enum sdiv_seq_state_t.
  - constants DBUS_W=16 and DIVIDEND_W=32.
- The watchdog counter is a natural sub-module: sdiv_wdog (clear, enable, terminal-count output, parameter TIMEOUT_CYCLES).
- Everything else is flat in sdiv_seq. Bench instantiates sdiv_seq plus the real sdiv.

Test Plan:
- Dividend 100, divisor 7 -> div_dbus sequence 0x0000, 0x0064, 0x0007 with div_st high only in the first cycle; out_quot=14, out_rem=2, out_ovf=0.
- Dividend -100 (0xFFFFFF9C), divisor 7 -> out_quot=0xFFF2 (-14), out_rem=0xFFFE (-2), out_ovf=0.
- Dividend 0x00010000, divisor 1 -> early divider exit; out_ovf=1, out_dz=0, out_to=0.
- Divisor 0, any dividend -> out_valid one cycle after the handshake; out_dz=1, out_ovf=1, quot=rem=0; div_st never asserted.
- Stub divider holding div_rdy low -> out_to=1 exactly TIMEOUT_CYCLES cycles after entering WAIT.
- Backpressure and reset:
  - out_ready low for 10 cycles -> out_valid and data stay stable, in_ready stays 0.
  - RST_N pulsed low during WAIT -> all outputs reset immediately; in_ready returns only after div_rdy=1; the next request 100/7 still yields 14 rem 2.
